piso_shift_tx: RTL and testbench

Parallel-in, serial-out shift transmitter built on edge-triggered flip-flop registers. It accepts a WIDTH-bit word through a Load/Ready handshake and drives it MSB-first on a single serial line, one bit per Clock. It is the transmit end of the team's serial register link, and its serial output feeds the serial-in/parallel-out capture register. Q/Qn follow the complementary-output convention of the team's flip-flop primitives.

---
 rtl/piso_shift_tx.sv | 186 ++++++++++++++++++
 tb/tb_piso_shift_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//
// Parallel-in, serial-out shift transmitter. A WIDTH-bit word is accepted
// through a Load/Ready handshake and sent MSB-first on Q, one bit per Clock.
// The serial line idles high, and Qn is always the complement of Q.
// Back-to-back frames are gap-free: a Load accepted at the edge that ends
// the last bit starts the next frame on the very next cycle.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When it is defined, an even-parity bit (the XOR of all data bits,
//   computed at capture) follows D[0]. That makes the frame WIDTH+1 bits
//   long, and Done/Ready move to the parity-bit cycle.
//
// Ports:
//   Clock  in   rising-edge clock
//   Reset  in   asynchronous, active-low reset
//   D      in   parallel word, sampled only when Load & Ready at an edge
//   Load   in   request to transmit D
//   Ready  out  transmitter accepts a word at the coming edge
//   Q      out  serial data, idles high
//   Qn     out  complement of Q, including during reset
//   Busy   out  a frame bit is on Q this cycle
//   Done   out  single-cycle pulse coincident with the last frame bit
//
// All outputs come directly from flip-flops.
// -----------------------------------------------------------------------------
module piso_shift_tx #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             Load,
    output logic             Ready,
    output logic             Q,
    output logic             Qn,
    output logic             Busy,
    output logic             Done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // The even-parity bit makes the XOR of data bits plus parity bit zero.
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    state_t             state_r, state_s;
    logic [FRAME-1:0]   shreg_r, shreg_s;
    logic [CNT_W-1:0]   cnt_r,   cnt_s;
    logic               q_r,     q_s;
    logic               qn_r;
    logic               busy_r,  busy_s;
    logic               done_r,  done_s;
    logic               ready_r, ready_s;
    logic [FRAME-1:0]   frame_s;
    logic               accept_s;
    logic               last_s;

    // Assemble the frame that would be captured: data word, plus parity bit if enabled.
    always_comb begin
`ifdef PISO_PARITY_EN
        frame_s = {D, even_parity(D)};
`else
        frame_s = D;
`endif
    end

    // Next-state and next-output logic.
    // The first frame bit goes straight into q_r at the accepting edge. The
    // shift register therefore holds only the bits that are still to be sent,
    // and the MSB of that register becomes the next Q.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        cnt_s    = cnt_r;
        q_s      = q_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        ready_s  = ready_r;
        accept_s = Load & ready_r;
        last_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    q_s     = frame_s[FRAME-1];
                    shreg_s = {frame_s[FRAME-2:0], 1'b0};
                    cnt_s   = CNT_W'(FRAME - 1);
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    ready_s = 1'b0;
                end else begin
                    state_s = IDLE;
                    q_s     = 1'b1;
                    shreg_s = {FRAME{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    // Mid-frame. Ready is low here, so Load is ignored.
                    last_s  = (cnt_r == CNT_W'(1));
                    state_s = SHIFT;
                    q_s     = shreg_r[FRAME-1];
                    shreg_s = {shreg_r[FRAME-2:0], 1'b0};
                    cnt_s   = cnt_r - CNT_W'(1);
                    busy_s  = 1'b1;
                    done_s  = last_s;
                    ready_s = last_s;
                end else if (accept_s) begin
                    // The last bit is ending and a new word is waiting, so the next frame starts with no gap.
                    state_s = SHIFT;
                    q_s     = frame_s[FRAME-1];
                    shreg_s = {frame_s[FRAME-2:0], 1'b0};
                    cnt_s   = CNT_W'(FRAME - 1);
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    ready_s = 1'b0;
                end else begin
                    state_s = IDLE;
                    q_s     = 1'b1;
                    shreg_s = {FRAME{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                    ready_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                q_s     = 1'b1;
                shreg_s = {FRAME{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
                busy_s  = 1'b0;
                done_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers, with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            shreg_r <= {FRAME{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            q_r     <= 1'b1;
            qn_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
            q_r     <= q_s;
            qn_r    <= ~q_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
        end
    end

    assign Q     = q_r;
    assign Qn    = qn_r;
    assign Busy  = busy_r;
    assign Done  = done_r;
    assign Ready = ready_r;

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
//
// Scoreboard bench for piso_shift_tx (WIDTH=8). Each accepted word pushes its
// frame bits to a queue. Each entry is {last, bit}. Every cycle, at the falling
// edge, one entry is popped (or the idle line is expected when the queue is
// empty), and Q, Qn, Busy, Done and Ready are compared against it.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FR = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FR = WIDTH;
    localparam bit PAR = 1'b0;
`endif

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] D;
    logic             Load;
    logic             Ready;
    logic             Q;
    logic             Qn;
    logic             Busy;
    logic             Done;

    int n_checks;
    int n_pass;
    logic [1:0] exp_q[$];
    logic model_ready;

    piso_shift_tx #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .D     (D),
        .Load  (Load),
        .Ready (Ready),
        .Q     (Q),
        .Qn    (Qn),
        .Busy  (Busy),
        .Done  (Done)
    );

    // 10-time-unit clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Single comparison point: count, then report a mismatch
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs against the next scoreboard entry (or idle)
    task automatic check_cycle(input string tag);
        logic [1:0] e;
        logic eq, eb, ed, er;
        eq = 1'b1; eb = 1'b0; ed = 1'b0; er = 1'b1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eq = e[0];
            eb = 1'b1;
            ed = e[1];
            er = e[1];
        end
        model_ready = er;
        check_val({tag, ".Q"},     {31'd0, Q},     {31'd0, eq});
        check_val({tag, ".Qn"},    {31'd0, Qn},    {31'd0, ~eq});
        check_val({tag, ".Busy"},  {31'd0, Busy},  {31'd0, eb});
        check_val({tag, ".Done"},  {31'd0, Done},  {31'd0, ed});
        check_val({tag, ".Ready"}, {31'd0, Ready}, {31'd0, er});
    endtask

    // Drive one cycle of stimulus, update the scoreboard on acceptance, then check
    task automatic step(input string tag, input logic ld, input logic [WIDTH-1:0] d);
        Load = ld;
        D    = d;
        @(posedge Clock);
        if (ld && model_ready) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                exp_q.push_back({(i == 0) && !PAR, d[i]});
            end
            if (PAR) begin
                exp_q.push_back({1'b1, ^d});
            end
        end
        @(negedge Clock);
        check_cycle(tag);
    endtask

    task automatic idle_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, WIDTH'($urandom));
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_ready = 1'b1;
        Reset       = 1'b0;
        Load        = 1'b0;
        D           = {WIDTH{1'b0}};

        // Reset state, held across edges with Load asserted
        Load = 1'b1;
        D    = 8'hFF;
        repeat (2) @(negedge Clock);
        check_cycle("rst");
        Load  = 1'b0;
        Reset = 1'b1;

        // Single frame A5, then idle
        step("a5", 1'b1, 8'hA5);
        idle_steps("a5", FR);

        // Back-to-back A5 then 3C, accepted in the Done cycle
        step("b2b", 1'b1, 8'hA5);
        idle_steps("b2b", FR - 1);
        step("b2b", 1'b1, 8'h3C);
        idle_steps("b2b", FR + 1);

        // Load while busy is ignored, and a new D must not disturb the frame in flight
        step("ign", 1'b1, 8'hFF);
        step("ign", 1'b0, 8'h00);
        step("ign", 1'b1, 8'h00);
        idle_steps("ign", FR);

        // Asynchronous reset mid-frame
        step("rmid", 1'b1, 8'h0F);
        idle_steps("rmid", 2);
        #2 Reset = 1'b0;
        #1;
        exp_q.delete();
        check_cycle("rmid_async");
        @(negedge Clock);
        Reset = 1'b1;
        check_cycle("rmid_hold");
        step("r81", 1'b1, 8'h81);
        idle_steps("r81", FR + 1);

        // Random loads with random D every cycle
        for (int i = 0; i < 200; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end
        idle_steps("tail", FR + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
